// File: rtl/fcl_bin_pkg.sv
// Shared types and arithmetic helpers for the binary FC layer engine.
// Pure combinational functions; no latency or flow control here.
package fcl_bin_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } fcl_state_t;

    // Widest activation beat a lane can take; lanes zero-pad into this width.
    localparam int MAX_BITS  = 256;
    localparam int ACC_DEF_W = 16;
    localparam int ACC_MAX   = (1 << (ACC_DEF_W - 1)) - 1;
    localparam int ACC_MIN   = -(1 << (ACC_DEF_W - 1));

    function automatic int popcount(input logic [MAX_BITS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_BITS; i++) begin
            cnt += int'(v[i]);
        end
        return cnt;
    endfunction

    // Signed add clamped to a two's-complement range of the given width (<= 31).
    function automatic int sat_add(input int a, input int b, input int width);
        int sum;
        int hi;
        int lo;
        sum = a + b;
        hi  = (1 << (width - 1)) - 1;
        lo  = -hi - 1;
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bin_xnor_pop_pe.sv
// One neuron lane: XNOR-popcount delta, saturating accumulate, load on first beat.
// sum_o is combinational for the current beat; acc updates on beat_en_i. No flow control.
module bin_xnor_pop_pe
    import fcl_bin_pkg::*;
#(
    parameter int IN_BITS   = 16,
    parameter int ACC_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        beat_en_i,
    input  logic                        first_i,
    input  logic [IN_BITS-1:0]          act_i,
    input  logic [IN_BITS-1:0]          w_i,
    output logic signed [ACC_WIDTH-1:0] sum_o
);

    logic [MAX_BITS-1:0]         match;
    int                          delta;
    int                          base;
    int                          sum;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;

    always_comb begin
        match              = '0;
        match[IN_BITS-1:0] = act_i ~^ w_i;
        delta              = 2 * popcount(match) - IN_BITS;
        // First beat of a vector ignores whatever the previous vector left behind.
        base               = first_i ? 0 : int'(acc_q);
        sum                = sat_add(base, delta, ACC_WIDTH);
        sum_o              = ACC_WIDTH'(sum);
        acc_d              = beat_en_i ? sum_o : acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fcl_bin_xnor_pop.sv
// Binary FC layer: NUM_NEURONS XNOR-popcount lanes over a programmable beat count.
// Result registered 1 clk after last beat; only a final beat stalls while a result is unconsumed.
module fcl_bin_xnor_pop
    import fcl_bin_pkg::*;
#(
    parameter int IN_BITS     = 16,
    parameter int NUM_NEURONS = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int BEAT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [BEAT_W-1:0]                cfg_beats,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_BITS-1:0]               in_act,
    input  logic [NUM_NEURONS*IN_BITS-1:0]   in_w,
    input  logic [NUM_NEURONS*ACC_WIDTH-1:0] thresh,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_NEURONS-1:0]           out_bits,
    output logic [NUM_NEURONS*ACC_WIDTH-1:0] out_acc
);

    fcl_state_t                       state_q, state_d;
    logic [BEAT_W-1:0]                beats_q, beats_d;
    logic [BEAT_W-1:0]                cnt_q, cnt_d;
    logic                             out_valid_q, out_valid_d;
    logic [NUM_NEURONS-1:0]           bits_q, bits_d;
    logic [NUM_NEURONS*ACC_WIDTH-1:0] acc_q, acc_d;
    logic [NUM_NEURONS*ACC_WIDTH-1:0] lane_sum;
    logic [NUM_NEURONS-1:0]           lane_ge;
    logic                             first_beat;
    logic                             last_beat;
    logic                             fire;

    assign first_beat = (state_q == IDLE);
    // cfg_beats of 0 or 1 makes the first beat also the last.
    assign last_beat  = first_beat ? (cfg_beats <= BEAT_W'(1))
                                   : (cnt_q == beats_q - BEAT_W'(1));
    assign in_ready   = !rst && (!out_valid_q || out_ready || !last_beat);
    assign fire       = in_valid && in_ready;

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
        logic signed [ACC_WIDTH-1:0] sum;

        bin_xnor_pop_pe #(
            .IN_BITS   (IN_BITS),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_pe (
            .clk       (clk),
            .rst       (rst),
            .beat_en_i (fire),
            .first_i   (first_beat),
            .act_i     (in_act),
            .w_i       (in_w[n*IN_BITS +: IN_BITS]),
            .sum_o     (sum)
        );

        assign lane_sum[n*ACC_WIDTH +: ACC_WIDTH] = sum;
        assign lane_ge[n] = (sum >= $signed(thresh[n*ACC_WIDTH +: ACC_WIDTH]));
    end

    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        acc_d       = acc_q;
        bits_d      = bits_q;
        if (fire) begin
            if (last_beat) begin
                // A publish overrides the consume, so back-to-back results never bubble.
                state_d     = IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                acc_d       = lane_sum;
                bits_d      = lane_ge;
            end else begin
                state_d = ACCUM;
                cnt_d   = cnt_q + BEAT_W'(1);
                if (first_beat) begin
                    beats_d = cfg_beats;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beats_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            bits_q      <= '0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            bits_q      <= bits_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_bits  = bits_q;

endmodule

// File: tb/tb_fcl_bin_xnor_pop.sv
// Bench for fcl_bin_xnor_pop: vector-level model plus scoreboard, directed vectors,
// and a second instance at ACC_WIDTH=8 for saturation.
module tb_fcl_bin_xnor_pop;

    typedef struct packed {
        logic [127:0] acc;
        logic [7:0]   bits;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  cfg_beats;
    logic         in_valid, in_ready;
    logic [15:0]  in_act;
    logic [127:0] in_w;
    logic [127:0] thresh;
    logic         out_valid, out_ready;
    logic [7:0]   out_bits;
    logic [127:0] out_acc;

    logic [15:0]  cfg_beats8;
    logic         in_valid8, in_ready8;
    logic [15:0]  in_act8;
    logic [127:0] in_w8;
    logic [63:0]  thresh8;
    logic         out_valid8, out_ready8;
    logic [7:0]   out_bits8;
    logic [63:0]  out_acc8;

    int           checks = 0;
    int           failures = 0;
    int           run[8];
    int           m_cnt = 0;
    int           m_len = 1;
    int           n_consumed = 0;
    res_t         exp_q[$];
    logic [127:0] got_acc;
    logic [7:0]   got_bits;

    always #5 clk = ~clk;

    fcl_bin_xnor_pop dut (
        .clk(clk), .rst(rst), .cfg_beats(cfg_beats), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_w(in_w), .thresh(thresh), .out_valid(out_valid),
        .out_ready(out_ready), .out_bits(out_bits), .out_acc(out_acc)
    );

    fcl_bin_xnor_pop #(.ACC_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .cfg_beats(cfg_beats8), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_act(in_act8), .in_w(in_w8), .thresh(thresh8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_bits(out_bits8), .out_acc(out_acc8)
    );

    task automatic chk(input bit ok, input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic int lane(input logic [127:0] v, input int n);
        return int'($signed(v[n*16 +: 16]));
    endfunction

    // Vector-level model: signed running sum of (matches - mismatches), clamped each beat.
    task automatic model_beat(input logic [15:0] act, input logic [127:0] w, input logic [127:0] th);
        res_t        e;
        logic [15:0] m;
        int          s;
        if (m_cnt == 0) m_len = (cfg_beats == 0) ? 1 : int'(cfg_beats);
        for (int n = 0; n < 8; n++) begin
            m = ~(act ^ w[n*16 +: 16]);
            s = ((m_cnt == 0) ? 0 : run[n]) + 2 * $countones(m) - 16;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            run[n] = s;
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            for (int n = 0; n < 8; n++) begin
                e.acc[n*16 +: 16] = 16'(run[n]);
                e.bits[n]         = (run[n] >= int'($signed(th[n*16 +: 16])));
            end
            exp_q.push_back(e);
            m_cnt = 0;
        end
    endtask

    task automatic send_beat(input logic [15:0] act, input logic [127:0] w, input logic [127:0] th);
        bit ok;
        ok = 0;
        in_act = act; in_w = w; thresh = th; in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                model_beat(act, w, th);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk(ok, "beat_accept_timeout", 128'(ok), 128'd1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        chk(done, "drain_timeout", 128'(exp_q.size()), 128'd0);
        @(posedge clk); #1;
        chk(out_valid == 1'b0, "valid_drops_after_consume", 128'(out_valid), 128'd0);
    endtask

    task automatic run8(input logic [127:0] w, input logic [7:0] exp_lane, input logic [7:0] exp_bits);
        int cnt;
        cnt = 0;
        in_act8 = 16'hFFFF; in_w8 = w; in_valid8 = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready8) cnt++;
            if (cnt == 10) break;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk(cnt == 10, "sat_beats_accepted", 128'(cnt), 128'd10);
        chk(out_valid8 == 1'b1, "sat_valid", 128'(out_valid8), 128'd1);
        for (int n = 0; n < 8; n++)
            chk(out_acc8[n*8 +: 8] == exp_lane, "sat_lane", 128'(out_acc8[n*8 +: 8]), 128'(exp_lane));
        chk(out_bits8 == exp_bits, "sat_bits", 128'(out_bits8), 128'(exp_bits));
    endtask

    // Scoreboard: every consumed result must match the model; held results must not move.
    bit           prev_hold = 0;
    logic [127:0] held_acc;
    logic [7:0]   held_bits;
    always @(negedge clk) begin : cmp
        res_t e;
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold && out_valid) begin
                chk(out_acc == held_acc, "hold_acc_stable", out_acc, held_acc);
                chk(out_bits == held_bits, "hold_bits_stable", 128'(out_bits), 128'(held_bits));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_result", 128'(out_valid), 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(out_acc == e.acc, "result_acc", out_acc, e.acc);
                    chk(out_bits == e.bits, "result_bits", 128'(out_bits), 128'(e.bits));
                    got_acc  = out_acc;
                    got_bits = out_bits;
                    n_consumed++;
                end
            end
            prev_hold = out_valid && !out_ready;
            held_acc  = out_acc;
            held_bits = out_bits;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_beats = '0;
        in_act = '0; in_w = '0; thresh = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; cfg_beats8 = 16'd10;
        in_act8 = '0; in_w8 = '0; thresh8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(in_ready == 1'b0, "ready_low_in_reset", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b0, "reset_valid", 128'(out_valid), 128'd0);
        chk(out_acc == '0, "reset_acc", out_acc, 128'd0);
        chk(out_bits == '0, "reset_bits", 128'(out_bits), 128'd0);
        chk(in_ready == 1'b1, "ready_after_reset", 128'(in_ready), 128'd1);
        @(posedge clk); #1;

        // All-match, 4 beats
        cfg_beats = 16'd4;
        for (int i = 0; i < 3; i++) send_beat(16'hFFFF, {8{16'hFFFF}}, '0);
        chk(out_valid == 1'b0, "t1_no_early_valid", 128'(out_valid), 128'd0);
        send_beat(16'hFFFF, {8{16'hFFFF}}, '0);
        chk(out_valid == 1'b1, "t1_latency_1clk", 128'(out_valid), 128'd1);
        wait_drain();
        for (int n = 0; n < 8; n++) chk(lane(got_acc, n) == 64, "t1_lane_64", got_acc, 128'd64);
        chk(got_bits == 8'hFF, "t1_bits", 128'(got_bits), 128'hFF);

        // All-mismatch, then lane 0 flipped to match
        cfg_beats = 16'd3;
        for (int i = 0; i < 3; i++) send_beat(16'hA5A5, {8{16'h5A5A}}, '0);
        wait_drain();
        chk(lane(got_acc, 0) == -48, "t2_lane0_m48", got_acc, 128'(-48));
        chk(lane(got_acc, 5) == -48, "t2_lane5_m48", got_acc, 128'(-48));
        chk(got_bits == 8'h00, "t2_bits", 128'(got_bits), 128'h00);
        for (int i = 0; i < 3; i++) send_beat(16'hA5A5, {{7{16'h5A5A}}, 16'hA5A5}, '0);
        wait_drain();
        chk(lane(got_acc, 0) == 48, "t2_lane0_p48", got_acc, 128'd48);
        chk(lane(got_acc, 1) == -48, "t2_lane1_m48", got_acc, 128'(-48));
        chk(got_bits == 8'h01, "t2b_bits", 128'(got_bits), 128'h01);

        // Backpressure: final beat of vector 2 stalls behind unconsumed result 1
        out_ready = 1'b0;
        cfg_beats = 16'd2;
        for (int i = 0; i < 2; i++)
            send_beat(16'hFFFF, {16'h0000, 16'h0001, 16'h0003, 16'h0007,
                                 16'h000F, 16'h001F, 16'h003F, 16'h007F}, '0);
        send_beat(16'h0000, {16'h0000, 16'h0001, 16'h0003, 16'h0007,
                             16'h000F, 16'h001F, 16'h003F, 16'h007F}, '0);
        chk(out_valid == 1'b1, "t3_result1_held", 128'(out_valid), 128'd1);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk(in_ready == 1'b0, "t3_final_beat_stalls", 128'(in_ready), 128'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_beat(16'h0000, {16'h0000, 16'h0001, 16'h0003, 16'h0007,
                             16'h000F, 16'h001F, 16'h003F, 16'h007F}, '0);
        chk(out_valid == 1'b1, "t3_no_bubble", 128'(out_valid), 128'd1);
        wait_drain();
        chk(lane(got_acc, 0) == 4, "t3_v2_lane0", got_acc, 128'd4);
        chk(lane(got_acc, 7) == 32, "t3_v2_lane7", got_acc, 128'd32);

        // Saturation at ACC_WIDTH=8
        run8({8{16'hFFFF}}, 8'h7F, 8'hFF);
        run8({8{16'h0000}}, 8'h80, 8'h00);

        // Reset mid-vector discards the partial sum
        cfg_beats = 16'd4;
        for (int i = 0; i < 2; i++) send_beat(16'h1234, {8{16'h1234}}, '0);
        rst = 1'b1;
        m_cnt = 0;
        @(negedge clk);
        chk(in_ready == 1'b0, "t5_ready_in_reset", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk(out_valid == 1'b0, "t5_valid_cleared", 128'(out_valid), 128'd0);
        chk(out_acc == '0, "t5_acc_cleared", out_acc, 128'd0);
        cfg_beats = 16'd0;
        send_beat(16'h1234, {8{16'h1234}}, '0);
        wait_drain();
        for (int n = 0; n < 8; n++) chk(lane(got_acc, n) == 16, "t5_lane_16", got_acc, 128'd16);
        chk(got_bits == 8'hFF, "t5_bits", 128'(got_bits), 128'hFF);

        // Threshold ties and mid-vector cfg change
        cfg_beats = 16'd2;
        for (int i = 0; i < 2; i++) send_beat(16'hC3C3, {8{16'hC3C3}}, {8{16'd32}});
        wait_drain();
        chk(got_bits == 8'hFF, "t6_tie_bits", 128'(got_bits), 128'hFF);
        send_beat(16'hC3C3, {8{16'hC3C3}}, {8{16'd32}});
        cfg_beats = 16'd5;
        send_beat(16'hC3C3, {8{16'hC3C3}}, {4{16'd33, 16'd32}});
        chk(out_valid == 1'b1, "t6_cfg_change_ignored", 128'(out_valid), 128'd1);
        wait_drain();
        chk(got_bits == 8'h55, "t6_mixed_thresh_bits", 128'(got_bits), 128'h55);
        chk(lane(got_acc, 1) == 32, "t6_lane1_32", got_acc, 128'd32);

        chk(n_consumed == 8, "result_count", 128'(n_consumed), 128'd8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
